// File: rtl/gpio_shift_out.sv
// gpio_shift_out: serializes a PIO output value onto a 74HC595-style chain.
// Resends on value change, on refresh, and once after every reset.
module gpio_shift_out #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_port,
    input  logic                  refresh,
    output logic                  sr_data,
    output logic                  sr_clk,
    output logic                  sr_latch,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic                  half, half_n;
    logic [BW-1:0]         bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0] shift_reg, shift_reg_n;
    logic [DATA_WIDTH-1:0] last_sent, last_sent_n;
    logic                  pending, pending_n;
    logic                  sr_data_d, sr_clk_d, sr_latch_d;
    logic                  busy_d, frame_done_d;
    logic                  start, cnt_wrap;

    assign start    = (in_port != last_sent) || pending || refresh;
    assign cnt_wrap = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            half       <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            last_sent  <= '0;
            pending    <= 1'b1;
            sr_data    <= 1'b0;
            sr_clk     <= 1'b0;
            sr_latch   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            half       <= half_n;
            bit_cnt    <= bit_cnt_n;
            shift_reg  <= shift_reg_n;
            last_sent  <= last_sent_n;
            pending    <= pending_n;
            sr_data    <= sr_data_d;
            sr_clk     <= sr_clk_d;
            sr_latch   <= sr_latch_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
        end
    end

    // half=0 is the low half of a bit slot, half=1 the high half
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        half_n      = half;
        bit_cnt_n   = bit_cnt;
        shift_reg_n = shift_reg;
        last_sent_n = last_sent;
        pending_n   = pending;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n     = SHIFT;
                    cnt_n       = '0;
                    half_n      = 1'b0;
                    bit_cnt_n   = '0;
                    shift_reg_n = in_port;
                    last_sent_n = in_port;
                    pending_n   = 1'b0;
                end
            end
            SHIFT: begin
                if (refresh) pending_n = 1'b1;
                cnt_n = cnt_wrap ? '0 : cnt + 1'b1;
                if (cnt_wrap) begin
                    half_n = ~half;
                    if (half) begin
                        if (bit_cnt == BIT_LAST) begin
                            state_n = LATCH;
                        end else begin
                            bit_cnt_n   = bit_cnt + 1'b1;
                            shift_reg_n = MSB_FIRST ? (shift_reg << 1)
                                                    : (shift_reg >> 1);
                        end
                    end
                end
            end
            LATCH: begin
                if (refresh) pending_n = 1'b1;
                cnt_n = cnt_wrap ? '0 : cnt + 1'b1;
                if (cnt_wrap) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // outputs are computed from next-state values and then registered
    always_comb begin
        sr_data_d    = 1'b0;
        sr_clk_d     = 1'b0;
        sr_latch_d   = 1'b0;
        busy_d       = (state_n != IDLE);
        frame_done_d = (state == LATCH) && (state_n == IDLE);
        unique case (state_n)
            SHIFT: begin
                sr_clk_d  = half_n;
                sr_data_d = MSB_FIRST ? shift_reg_n[DATA_WIDTH-1]
                                      : shift_reg_n[0];
            end
            LATCH:   sr_latch_d = 1'b1;
            default: sr_latch_d = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_gpio_shift_out.sv
// tb_gpio_shift_out: frame-level model checks two configurations cycle by cycle.
// Directed vectors exercise auto, change, refresh and reset-abort frames.
module tb_gpio_shift_out;
    logic       clk;
    logic       reset_n;
    logic [7:0] in0, in2;
    logic       rf0, rf2;
    logic       d0, c0, l0, b0, f0;
    logic       d1, c1, l1, b1, f1;
    logic [4:0] o0, o1, oa, oe;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 0;

    bit         m_act[2];
    bit         m_pend[2];
    bit         m_fd[2];
    int         m_k[2];
    logic [7:0] m_val[2];
    logic [7:0] m_last[2];

    logic [7:0] sh[2];
    bit pc[2], pl[2], pb[2];
    int brun[2], lrun[2];
    int fv[2][16], rc[2][16], dc[2][16], lc[2][16], bl[2][16], ll[2][16];
    int nf[2], nr[2], nd[2], nl[2], nb[2], nll[2];

    gpio_shift_out u_dut0 (
        .clk(clk), .reset_n(reset_n), .in_port(in0), .refresh(rf0),
        .sr_data(d0), .sr_clk(c0), .sr_latch(l0), .busy(b0),
        .frame_done(f0)
    );

    gpio_shift_out #(.DATA_WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_port(in2), .refresh(rf2),
        .sr_data(d1), .sr_clk(c1), .sr_latch(l1), .busy(b1),
        .frame_done(f1)
    );

    assign o0 = {d0, c0, l0, b0, f0};
    assign o1 = {d1, c1, l1, b1, f1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cdv(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic bit msbv(input int i);
        return (i == 0);
    endfunction

    // frame position k runs 1..17*cd; bit slots first, then the latch pulse
    task automatic mstep(input int i, input logic [7:0] inp, input logic rf);
        int len;
        len = 17 * cdv(i);
        if (!reset_n) begin
            m_act[i] = 0; m_fd[i] = 0; m_k[i] = 0;
            m_last[i] = 8'h00; m_pend[i] = 1;
        end else if (m_act[i]) begin
            if (rf) m_pend[i] = 1;
            if (m_k[i] == len) begin
                m_act[i] = 0; m_fd[i] = 1;
            end else begin
                m_k[i] = m_k[i] + 1;
            end
        end else begin
            m_fd[i] = 0;
            if (inp != m_last[i] || m_pend[i] || rf) begin
                m_act[i] = 1; m_k[i] = 1; m_val[i] = inp;
                m_last[i] = inp; m_pend[i] = 0;
            end
        end
    endtask

    function automatic logic [4:0] mexp(input int i);
        int cd, slot, w, idx;
        cd = cdv(i);
        if (!m_act[i]) return {4'b0000, m_fd[i]};
        if (m_k[i] <= 16 * cd) begin
            slot = (m_k[i] - 1) / (2 * cd);
            w    = (m_k[i] - 1) % (2 * cd);
            idx  = msbv(i) ? 7 - slot : slot;
            return {m_val[i][idx], (w >= cd), 1'b0, 1'b1, 1'b0};
        end
        return 5'b00110;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        mstep(0, in0, rf0);
        mstep(1, in2, rf2);
        if (!reset_n) chk_en = 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                oa = (i == 0) ? o0 : o1;
                oe = mexp(i);
                n_chk++;
                if (oa !== oe) begin
                    n_fail++;
                    $display("FAIL outputs dut%0d cyc %0d: got %b expected %b",
                             i, cyc, oa, oe);
                end
                if (oa[3] && !pc[i]) sh[i] = {sh[i][6:0], oa[4]};
                if (oa[2] && !pl[i]) begin
                    if (nf[i] < 16) fv[i][nf[i]] = int'(sh[i]);
                    if (nl[i] < 16) lc[i][nl[i]] = cyc;
                    nf[i]++; nl[i]++;
                end
                if (oa[1] && !pb[i]) begin
                    if (nr[i] < 16) rc[i][nr[i]] = cyc;
                    nr[i]++;
                end
                if (oa[0]) begin
                    if (nd[i] < 16) dc[i][nd[i]] = cyc;
                    nd[i]++;
                end
                if (oa[1]) brun[i]++;
                else if (pb[i]) begin
                    if (nb[i] < 16) bl[i][nb[i]] = brun[i];
                    nb[i]++; brun[i] = 0;
                end
                if (oa[2]) lrun[i]++;
                else if (pl[i]) begin
                    if (nll[i] < 16) ll[i][nll[i]] = lrun[i];
                    nll[i]++; lrun[i] = 0;
                end
                pc[i] = oa[3]; pl[i] = oa[2]; pb[i] = oa[1];
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 16; j++) begin
                fv[i][j] = -1; rc[i][j] = -1; dc[i][j] = -1;
                lc[i][j] = -1; bl[i][j] = -1; ll[i][j] = -1;
            end
            nf[i] = 0; nr[i] = 0; nd[i] = 0; nl[i] = 0;
            nb[i] = 0; nll[i] = 0; brun[i] = 0; lrun[i] = 0;
            sh[i] = 8'h00; pc[i] = 0; pl[i] = 0; pb[i] = 0;
        end
        reset_n = 1'b0;
        in0 = 8'h00; rf0 = 1'b0;
        in2 = 8'h01; rf2 = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // automatic frame after reset
        repeat (90) @(negedge clk);
        check("t1_val", fv[0][0], 0);
        check("t1_busy_len", bl[0][0], 68);
        check("t1_latch_len", ll[0][0], 4);
        check("t1_done_cnt", nd[0], 1);
        check("t6_val", fv[1][0], 128);
        check("t6_busy_len", bl[1][0], 17);
        check("t6_latch_len", ll[1][0], 1);
        repeat (100) @(negedge clk);
        check("t1_quiet", nr[0], 1);

        // value change, then changes during the frame
        in0 = 8'hA5;
        repeat (10) @(negedge clk);
        in0 = 8'h3C;
        repeat (10) @(negedge clk);
        in0 = 8'hFF;
        repeat (170) @(negedge clk);
        check("t2_val", fv[0][1], 165);
        check("t2_done_ofs", dc[0][1] - rc[0][1], 68);
        check("t2_latch_ofs", lc[0][1] - rc[0][1], 64);
        check("t3_val", fv[0][2], 255);
        check("t3_gap", rc[0][2] - dc[0][1], 1);
        check("t3_frames", nf[0], 3);

        // refresh in idle, then three refreshes mid-frame
        rf0 = 1'b1;
        @(negedge clk);
        rf0 = 1'b0;
        repeat (10) @(negedge clk);
        repeat (3) begin
            rf0 = 1'b1;
            @(negedge clk);
            rf0 = 1'b0;
            repeat (5) @(negedge clk);
        end
        repeat (170) @(negedge clk);
        check("t4_frames", nf[0], 5);
        check("t4_val_a", fv[0][3], 255);
        check("t4_val_b", fv[0][4], 255);
        check("t4_gap", rc[0][4] - dc[0][3], 1);

        // reset during bit slot 3
        in0 = 8'h5A;
        repeat (27) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (90) @(negedge clk);
        check("t5_abort_len", bl[0][5], 27);
        check("t5_frames", nf[0], 6);
        check("t5_val", fv[0][5], 90);
        check("t5_done_cnt", nd[0], 6);
        check("t5_dut1_frames", nf[1], 2);
        check("t5_dut1_val", fv[1][1], 128);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
